// File: rtl/mic_array_pkg.sv
// Shared constants, sample/channel types and the receive FSM encoding for the mic array front end.
// Latency: none (declarations and a combinational helper only).
// Backpressure: not applicable.
package mic_array_pkg;

  localparam int MIC_N_CH      = 16;
  localparam int MIC_SLOT_BITS = 32;
  localparam int MIC_DATA_W    = 24;
  localparam int MIC_CH_W      = $clog2(MIC_N_CH);

  typedef logic signed [MIC_DATA_W-1:0] mic_sample_t;
  typedef logic        [MIC_CH_W-1:0]   mic_ch_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SHIFT     = 2'd1,
    WAIT_SYNC = 2'd2
  } mic_rx_state_e;

  // Saturating increment for the 16-bit malformed-frame counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous pin, with an optional registered rising-edge pulse.
// Latency: level is STAGES clk behind the pin; rise is one further clk behind the level.
// Backpressure: none; free-running sampler.
module sync_edge_detect #(
  parameter int STAGES  = 2,
  parameter bit EDGE_EN = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic level,
  output logic rise
);

  logic [STAGES-1:0] sync_q;

  // Synchronizer chain: stage 0 takes the raw pin, the last stage is the usable level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign level = sync_q[STAGES-1];

  generate
    if (EDGE_EN) begin : g_edge
      logic prev_q;
      logic rise_q;

      // Registered rising-edge detect on the synchronized level.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          prev_q <= 1'b0;
          rise_q <= 1'b0;
        end else begin
          prev_q <= level;
          rise_q <= level & ~prev_q;
        end
      end

      assign rise = rise_q;
    end else begin : g_no_edge
      assign rise = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/mic_array_tdm_rx.sv
// TDM microphone-array receiver: deserializes sck/ws/sd into per-slot signed samples on an Avalon-ST stream.
// Latency: valid rises 1 clk after the bit_tick carrying the last bit of a slot (bit_tick is SYNC_STAGES+1 clk after the sck pin edge).
// Backpressure: none; every valid beat must be taken, beats are at least SLOT_BITS bit_ticks apart.
module mic_array_tdm_rx
  import mic_array_pkg::*;
#(
  parameter int N_CH        = MIC_N_CH,
  parameter int SLOT_BITS   = MIC_SLOT_BITS,
  parameter int DATA_W      = MIC_DATA_W,
  parameter int SYNC_STAGES = 2,
  localparam int CH_W       = $clog2(N_CH),
  localparam int BIT_W      = $clog2(SLOT_BITS)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     sck_in,
  input  logic                     ws_in,
  input  logic                     sd_in,
  output logic signed [DATA_W-1:0] avalon_st_data,
  output logic [CH_W-1:0]          avalon_st_channel,
  output logic                     avalon_st_valid,
  output logic                     avalon_st_startofpacket,
  output logic                     avalon_st_endofpacket,
  output logic                     frame_error,
  output logic [15:0]              error_count
);

  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(SLOT_BITS - 1);
  localparam logic [CH_W-1:0]  LAST_SLOT = CH_W'(N_CH - 1);

  logic bit_tick;
  logic ws_s;
  logic sd_s;
  logic sck_level_unused;
  logic ws_rise_unused;
  logic sd_rise_unused;

  sync_edge_detect #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_sync_sck (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (sck_in),
    .level   (sck_level_unused),
    .rise    (bit_tick)
  );

  sync_edge_detect #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_sync_ws (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (ws_in),
    .level   (ws_s),
    .rise    (ws_rise_unused)
  );

  sync_edge_detect #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_sync_sd (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (sd_in),
    .level   (sd_s),
    .rise    (sd_rise_unused)
  );

  mic_rx_state_e     state_q, state_n;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_n;
  logic [CH_W-1:0]   slot_cnt_q, slot_cnt_n;
  logic [DATA_W-1:0] shreg_q, shreg_n;
  logic              ws_prev_q;
  logic              frame_start;
  logic              restart;
  logic              emit;
  logic              err;

  // A frame starts on the bit whose ws sample is high and whose predecessor was low.
  assign frame_start = bit_tick & ws_s & ~ws_prev_q;

  // ws history is tracked on every bit regardless of enable, so re-enabling
  // while ws is already high cannot fake a frame start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ws_prev_q <= 1'b0;
    end else if (bit_tick) begin
      ws_prev_q <= ws_s;
    end
  end

  // Receive FSM state and bit/slot position registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      slot_cnt_q <= '0;
      shreg_q    <= '0;
    end else begin
      state_q    <= state_n;
      bit_cnt_q  <= bit_cnt_n;
      slot_cnt_q <= slot_cnt_n;
      shreg_q    <= shreg_n;
    end
  end

  // Next-state logic: the counters name the next bit to receive, so a frame
  // start consumes bit 0 of slot 0 and leaves the bit counter at 1.
  always_comb begin
    state_n    = state_q;
    bit_cnt_n  = bit_cnt_q;
    slot_cnt_n = slot_cnt_q;
    shreg_n    = shreg_q;
    restart    = 1'b0;
    emit       = 1'b0;
    err        = 1'b0;

    if (!enable) begin
      state_n    = IDLE;
      bit_cnt_n  = '0;
      slot_cnt_n = '0;
    end else if (bit_tick) begin
      case (state_q)
        IDLE: begin
          restart = frame_start;
        end
        SHIFT: begin
          if (frame_start) begin
            // Early sync: drop the partial slot, count it, and start over on this bit.
            restart = 1'b1;
            err     = (bit_cnt_q != '0) || (slot_cnt_q != '0);
          end else begin
            if (32'(bit_cnt_q) < DATA_W) begin
              shreg_n = {shreg_q[DATA_W-2:0], sd_s};
            end
            if (bit_cnt_q == LAST_BIT) begin
              emit      = 1'b1;
              bit_cnt_n = '0;
              if (slot_cnt_q == LAST_SLOT) begin
                state_n    = WAIT_SYNC;
                slot_cnt_n = '0;
              end else begin
                slot_cnt_n = slot_cnt_q + CH_W'(1);
              end
            end else begin
              bit_cnt_n = bit_cnt_q + BIT_W'(1);
            end
          end
        end
        WAIT_SYNC: begin
          restart = frame_start;
        end
        default: begin
          state_n = IDLE;
        end
      endcase

      if (restart) begin
        state_n    = SHIFT;
        slot_cnt_n = '0;
        bit_cnt_n  = BIT_W'(1);
        shreg_n    = {shreg_q[DATA_W-2:0], sd_s};
      end
    end
  end

  // Output registers: a beat carries the completed slot; metadata holds until the next beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avalon_st_data          <= '0;
      avalon_st_channel       <= '0;
      avalon_st_valid         <= 1'b0;
      avalon_st_startofpacket <= 1'b0;
      avalon_st_endofpacket   <= 1'b0;
      frame_error             <= 1'b0;
      error_count             <= '0;
    end else begin
      avalon_st_valid <= emit;
      frame_error     <= err;
      if (emit) begin
        avalon_st_data          <= $signed(shreg_n);
        avalon_st_channel       <= slot_cnt_q;
        avalon_st_startofpacket <= (slot_cnt_q == '0);
        avalon_st_endofpacket   <= (slot_cnt_q == LAST_SLOT);
      end
      if (err) begin
        error_count <= sat_inc16(error_count);
      end
    end
  end

endmodule

// File: tb/tb_mic_array_tdm_rx.sv
// Self-checking bench for mic_array_tdm_rx: serial frames in, scoreboard of expected beats out.
// Latency: expectations are queued when a slot's last bit is driven and matched whenever valid is seen.
// Backpressure: none; every beat is consumed by the compare process.
`timescale 1ns/1ps
module tb_mic_array_tdm_rx;

  localparam int NCH = 16;
  localparam int SB  = 32;
  localparam int FRAME_BITS = NCH * SB;

  logic               clk     = 1'b0;
  logic               reset_n = 1'b0;
  logic               enable  = 1'b0;
  logic               sck_in  = 1'b0;
  logic               ws_in   = 1'b0;
  logic               sd_in   = 1'b0;
  logic signed [23:0] avalon_st_data;
  logic [3:0]         avalon_st_channel;
  logic               avalon_st_valid;
  logic               avalon_st_startofpacket;
  logic               avalon_st_endofpacket;
  logic               frame_error;
  logic [15:0]        error_count;

  // 100 MHz system clock; sck at clk/6 keeps the run short while honouring the 4x minimum.
  always #5 clk = ~clk;
  always #30 sck_in = ~sck_in;

  mic_array_tdm_rx dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .enable                  (enable),
    .sck_in                  (sck_in),
    .ws_in                   (ws_in),
    .sd_in                   (sd_in),
    .avalon_st_data          (avalon_st_data),
    .avalon_st_channel       (avalon_st_channel),
    .avalon_st_valid         (avalon_st_valid),
    .avalon_st_startofpacket (avalon_st_startofpacket),
    .avalon_st_endofpacket   (avalon_st_endofpacket),
    .frame_error             (frame_error),
    .error_count             (error_count)
  );

  typedef struct {
    logic [23:0] data;
    logic [3:0]  ch;
    logic        sop;
    logic        eop;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       cmp_e;
  int          n_vec = 0;
  int          n_err = 0;
  int          fe_pulses = 0;
  logic [15:0] exp_err = 16'd0;
  logic [23:0] cap_data [NCH];
  logic [31:0] words [NCH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Compare process: every valid beat must match the head of the expectation queue.
  always @(negedge clk) begin
    if (reset_n && frame_error) fe_pulses++;
    if (reset_n && avalon_st_valid) begin
      cap_data[avalon_st_channel] = avalon_st_data;
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        cmp_e = exp_q.pop_front();
        chk("beat_data", {8'd0, avalon_st_data}, {8'd0, cmp_e.data});
        chk("beat_channel", {28'd0, avalon_st_channel}, {28'd0, cmp_e.ch});
        chk("beat_sop", {31'd0, avalon_st_startofpacket}, {31'd0, cmp_e.sop});
        chk("beat_eop", {31'd0, avalon_st_endofpacket}, {31'd0, cmp_e.eop});
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, avalon_st_valid}, 32'd0);
    chk({tag, "_data"}, {8'd0, avalon_st_data}, 32'd0);
    chk({tag, "_channel"}, {28'd0, avalon_st_channel}, 32'd0);
    chk({tag, "_sop"}, {31'd0, avalon_st_startofpacket}, 32'd0);
    chk({tag, "_eop"}, {31'd0, avalon_st_endofpacket}, 32'd0);
    chk({tag, "_frame_error"}, {31'd0, frame_error}, 32'd0);
    chk({tag, "_error_count"}, {16'd0, error_count}, 32'd0);
  endtask

  task automatic randomize_words();
    for (int k = 0; k < NCH; k++) words[k] = $urandom;
  endtask

  task automatic do_reset_mid();
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_zero("midreset");
    exp_err = 16'd0;
    repeat (2) @(negedge clk);
    check_zero("midreset_hold");
    reset_n = 1'b1;
  endtask

  // Drives n_bits of a frame (ws high on bit 0 only). While the receiver is armed,
  // each fully sent slot becomes one expected beat; an incomplete frame counts as
  // a malformed one when the next frame starts.
  task automatic send_frame(input int n_bits, input bit armed, input int drop_at, input int rst_at);
    for (int i = 0; i < n_bits; i++) begin
      int s;
      int b;
      s = i / SB;
      b = i % SB;
      @(negedge sck_in);
      ws_in = (i == 0);
      sd_in = words[s][31-b];
      if (i == drop_at) begin
        @(negedge clk);
        enable = 1'b0;
        armed  = 1'b0;
      end
      if (i == rst_at) begin
        do_reset_mid();
        armed = 1'b0;
      end
      if (armed && b == SB - 1)
        exp_q.push_back('{words[s][31:8], 4'(s), (s == 0), (s == NCH - 1)});
    end
    if (armed && n_bits < FRAME_BITS && exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
  endtask

  task automatic send_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge sck_in);
      ws_in = 1'b0;
      sd_in = 1'($urandom);
    end
  endtask

  task automatic drain_check(input string tag, input int exp_pulses);
    repeat (20) @(negedge clk);
    chk({tag, "_pending_beats"}, exp_q.size(), 32'd0);
    chk({tag, "_frame_error_pulses"}, fe_pulses, exp_pulses);
    chk({tag, "_error_count"}, {16'd0, error_count}, {16'd0, exp_err});
  endtask

  initial begin
    repeat (5) @(negedge clk);
    check_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    send_idle(5);

    // Normal frame: slot k = {0x800000+k, 0xFF}.
    for (int k = 0; k < NCH; k++) words[k] = {24'h800000 + 24'(k), 8'hFF};
    send_frame(FRAME_BITS, 1'b1, -1, -1);
    drain_check("normal", 0);
    chk("lit_normal_ch0", {8'd0, cap_data[0]}, 32'h0080_0000);
    chk("lit_normal_ch15", {8'd0, cap_data[15]}, 32'h0080_000F);

    // Sign and MSB alignment.
    randomize_words();
    words[3] = 32'hFFFF_FE00;
    words[4] = 32'h7FFF_FF00;
    send_frame(FRAME_BITS, 1'b1, -1, -1);
    drain_check("sign", 0);
    chk("lit_sign_ch3", {8'd0, cap_data[3]}, 32'h00FF_FFFE);
    chk("lit_sign_ch4", {8'd0, cap_data[4]}, 32'h007F_FFFF);

    // Early sync at slot 5 bit 10, then a clean frame.
    randomize_words();
    send_frame(5 * SB + 10, 1'b1, -1, -1);
    randomize_words();
    send_frame(FRAME_BITS, 1'b1, -1, -1);
    drain_check("early", 1);
    chk("lit_early_error_count", {16'd0, error_count}, 32'd1);

    // Early sync at a random position.
    randomize_words();
    send_frame($urandom_range(1, FRAME_BITS - 1), 1'b1, -1, -1);
    randomize_words();
    send_frame(FRAME_BITS, 1'b1, -1, -1);
    drain_check("random_early", 2);

    // Saturation: preload near the top, then two more early syncs.
    @(negedge clk);
    force dut.error_count = 16'hFFFE;
    @(negedge clk);
    release dut.error_count;
    exp_err = 16'hFFFE;
    @(negedge clk);
    chk("preload_error_count", {16'd0, error_count}, 32'h0000_FFFE);
    randomize_words();
    send_frame(40, 1'b1, -1, -1);
    send_frame(100, 1'b1, -1, -1);
    randomize_words();
    send_frame(FRAME_BITS, 1'b1, -1, -1);
    drain_check("saturate", 4);
    chk("lit_saturated", {16'd0, error_count}, 32'h0000_FFFF);

    // Enable dropped in the middle of slot 7, restored between frames.
    randomize_words();
    send_frame(FRAME_BITS, 1'b1, 7 * SB + 12, -1);
    send_idle(8);
    @(negedge clk);
    enable = 1'b1;
    send_idle(8);
    randomize_words();
    send_frame(FRAME_BITS, 1'b1, -1, -1);
    drain_check("enable", 4);

    // Asynchronous reset in the middle of slot 9.
    randomize_words();
    send_frame(FRAME_BITS, 1'b1, -1, 9 * SB + 5);
    send_idle(4);
    randomize_words();
    send_frame(FRAME_BITS, 1'b1, -1, -1);
    drain_check("reset_mid", 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
